if_fetch: RTL and testbench

Instruction-fetch stage sitting between the PC register and the IF/ID boundary. It issues one instruction-bus read per PC value using a req/ack handshake, stalls the PC while a read is outstanding, and registers the fetched word together with its PC for the decode stage. It also buffers one word across decode-stage stalls and discards in-flight reads on CP0 redirects, such as exceptions or ERET.

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_fetch.sv | 119 +++++++++++
 tb/tb_if_fetch.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and fetch-state encoding for the instruction-fetch stage.
package if_fetch_pkg;

  localparam logic        NOSTOP       = 1'b0;
  localparam logic        STOP         = 1'b1;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [31:0] NOPInst      = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_BUSY = 2'd1,
    IF_HOLD = 2'd2,
    IF_DROP = 2'd3
  } if_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: one req/ack bus read per PC, one-word skid buffer for
// decode stalls, and discard of in-flight reads when CP0 redirects the PC.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic        stallreq_o,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  if_state_t   state_reg, state_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_inst_reg, id_inst_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] buf_inst_reg, buf_inst_next;
  logic [31:0] addr_reg, addr_next;

  // Only the IF/ID and ID hold bits matter to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IF_IDLE;
      id_pc_reg    <= ZeroWord;
      id_inst_reg  <= NOPInst;
      buf_pc_reg   <= ZeroWord;
      buf_inst_reg <= NOPInst;
      addr_reg     <= ZeroWord;
    end else begin
      state_reg    <= state_next;
      id_pc_reg    <= id_pc_next;
      id_inst_reg  <= id_inst_next;
      buf_pc_reg   <= buf_pc_next;
      buf_inst_reg <= buf_inst_next;
      addr_reg     <= addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    id_pc_next    = id_pc_reg;
    id_inst_next  = id_inst_reg;
    buf_pc_next   = buf_pc_reg;
    buf_inst_next = buf_inst_reg;
    addr_next     = addr_reg;
    ibus_req      = 1'b0;
    ibus_addr     = addr_reg;
    stallreq_o    = NOSTOP;

    // IF/ID held but ID advancing: inject a bubble; loads below override.
    if (stall[1] && !stall[2]) begin
      id_pc_next   = ZeroWord;
      id_inst_next = NOPInst;
    end

    case (state_reg)
      IF_IDLE: begin
        stallreq_o = STOP;
        state_next = IF_BUSY;
      end
      IF_BUSY: begin
        ibus_req   = 1'b1;
        ibus_addr  = pc_i;
        stallreq_o = ibus_ack ? NOSTOP : STOP;
        addr_next  = pc_i;
        if (flush) begin
          state_next = ibus_ack ? IF_BUSY : IF_DROP;
        end else if (ibus_ack) begin
          if (!stall[1]) begin
            id_pc_next   = pc_i;
            id_inst_next = ibus_rdata;
          end else begin
            buf_pc_next   = pc_i;
            buf_inst_next = ibus_rdata;
            state_next    = IF_HOLD;
          end
        end
      end
      IF_HOLD: begin
        if (flush) begin
          state_next = IF_BUSY;
        end else if (!stall[1]) begin
          id_pc_next   = buf_pc_reg;
          id_inst_next = buf_inst_reg;
          state_next   = IF_BUSY;
        end
      end
      IF_DROP: begin
        // PC already holds the redirect target; finish the stale read first.
        ibus_req   = 1'b1;
        ibus_addr  = addr_reg;
        stallreq_o = STOP;
        if (!flush && ibus_ack) begin
          state_next = IF_BUSY;
        end
      end
      default: state_next = IF_IDLE;
    endcase

    if (flush) begin
      id_pc_next   = ZeroWord;
      id_inst_next = NOPInst;
    end
  end

  assign id_pc   = id_pc_reg;
  assign id_inst = id_inst_reg;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios with literal checks,
// then randomized traffic compared every cycle against a behavioural model.
module tb_if_fetch;

  localparam logic [31:0] KEY   = 32'hA5A5A5A5;
  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [5:0]  ext_stall;
  logic [5:0]  stall;
  logic        flush;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        stallreq_o;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int          wait_cfg;
  int          bus_cnt;
  logic [31:0] redirect_addr;

  int checks = 0;
  int errors = 0;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc),
    .stall      (stall),
    .flush      (flush),
    .ibus_req   (ibus_req),
    .ibus_addr  (ibus_addr),
    .ibus_ack   (ibus_ack),
    .ibus_rdata (ibus_rdata),
    .stallreq_o (stallreq_o),
    .id_pc      (id_pc),
    .id_inst    (id_inst)
  );

  always #5 clk = ~clk;

  // Controller: a fetch stall request freezes PC and IF/ID.
  assign stall = {ext_stall[5:2], ext_stall[1:0] | {2{stallreq_o}}};

  // Bus: acks once the request has waited wait_cfg cycles; data = addr ^ KEY.
  assign ibus_ack   = ibus_req && (bus_cnt >= wait_cfg);
  assign ibus_rdata = ibus_addr ^ KEY;

  // PC register and bus wait counter.
  always @(posedge clk) begin
    if (rst)            pc <= RST_PC;
    else if (flush)     pc <= redirect_addr;
    else if (!stall[0]) pc <= pc + 32'd4;

    if (rst || !ibus_req || ibus_ack) bus_cnt <= 0;
    else                              bus_cnt <= bus_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks what the fetch stage owes the pipeline: whether it is out of
  // reset, whether a word is parked for decode, and whether a stale read
  // must be drained before fetching the redirected PC.
  logic        m_valid = 1'b0;
  logic        m_active, m_parked, m_dropping;
  logic [31:0] m_drop_addr, m_id_pc, m_id_inst, m_buf_pc, m_buf_inst;

  always @(negedge clk) begin
    logic        exp_req, exp_stallreq, ack;
    logic [31:0] exp_addr;
    exp_req      = m_active && !m_parked;
    exp_addr     = m_dropping ? m_drop_addr : pc;
    ack          = exp_req && ibus_ack;
    exp_stallreq = !m_active || m_dropping || (exp_req && !ibus_ack);

    if (m_valid) begin
      check("ibus_req", {31'b0, ibus_req}, {31'b0, exp_req});
      if (exp_req) check("ibus_addr", ibus_addr, exp_addr);
      check("stallreq_o", {31'b0, stallreq_o}, {31'b0, exp_stallreq});
      check("id_pc", id_pc, m_id_pc);
      check("id_inst", id_inst, m_id_inst);
    end

    if (rst) begin
      m_valid = 1'b1; m_active = 1'b0; m_parked = 1'b0; m_dropping = 1'b0;
      m_drop_addr = 0; m_id_pc = 0; m_id_inst = 0; m_buf_pc = 0; m_buf_inst = 0;
    end else if (m_valid) begin
      logic load_now, bubble;
      load_now = 1'b0;
      bubble   = stall[1] && !stall[2];
      if (flush) begin
        m_id_pc = 0; m_id_inst = 0;
        if (!m_active) m_active = 1'b1;
        else if (m_parked) m_parked = 1'b0;
        else if (!m_dropping && !ack) begin
          m_dropping  = 1'b1;
          m_drop_addr = pc;
        end
      end else begin
        if (!m_active) begin
          m_active = 1'b1;
        end else if (m_dropping) begin
          if (ack) m_dropping = 1'b0;
        end else if (m_parked) begin
          if (!stall[1]) begin
            m_id_pc = m_buf_pc; m_id_inst = m_buf_inst; m_parked = 1'b0;
            load_now = 1'b1;
          end
        end else if (ack) begin
          if (!stall[1]) begin
            m_id_pc = pc; m_id_inst = pc ^ KEY; load_now = 1'b1;
          end else begin
            m_buf_pc = pc; m_buf_inst = pc ^ KEY; m_parked = 1'b1;
          end
        end
        if (!load_now && bubble) begin
          m_id_pc = 0; m_id_inst = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; ext_stall = 6'b0; flush = 1'b0; wait_cfg = 0;
    redirect_addr = 32'h80000180;
    repeat (2) tick;

    // Reset state and zero-wait fetch.
    rst = 1'b0; #1;
    $display("scenario: reset release");
    check("rst_req", {31'b0, ibus_req}, 32'd0);
    check("rst_stallreq", {31'b0, stallreq_o}, 32'd1);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_inst", id_inst, 32'h0);
    tick;
    check("zw_addr0", ibus_addr, 32'hbfc00000);
    check("zw_req0", {31'b0, ibus_req}, 32'd1);
    tick;
    // bfc00000 ^ a5a5a5a5 = 1a65a5a5
    check("zw_id_pc0", id_pc, 32'hbfc00000);
    check("zw_id_inst0", id_inst, 32'h1a65a5a5);
    check("zw_addr1", ibus_addr, 32'hbfc00004);
    tick;

    // Two wait states at bfc00008.
    $display("scenario: two wait states");
    wait_cfg = 2; #1;
    check("ws_id_inst_prev", id_inst, 32'h1a65a5a1);
    check("ws_stallreq0", {31'b0, stallreq_o}, 32'd1);
    check("ws_addr0", ibus_addr, 32'hbfc00008);
    tick;
    check("ws_bubble1", id_inst, 32'h0);
    check("ws_stallreq1", {31'b0, stallreq_o}, 32'd1);
    check("ws_addr1", ibus_addr, 32'hbfc00008);
    tick;
    check("ws_bubble2", id_inst, 32'h0);
    check("ws_stallreq2", {31'b0, stallreq_o}, 32'd0);
    check("ws_addr2", ibus_addr, 32'hbfc00008);
    wait_cfg = 0;
    tick;
    check("ws_id_pc", id_pc, 32'hbfc00008);
    check("ws_id_inst", id_inst, 32'h1a65a5ad);

    // Decode stall during ack.
    $display("scenario: decode stall during ack");
    ext_stall = 6'b000111; #1;
    tick;
    check("hold_req", {31'b0, ibus_req}, 32'd0);
    check("hold_stallreq", {31'b0, stallreq_o}, 32'd0);
    check("hold_id_pc", id_pc, 32'hbfc00008);
    tick;
    tick;
    ext_stall = 6'b0; #1;
    check("hold_req_last", {31'b0, ibus_req}, 32'd0);
    tick;
    check("hold_rel_id_pc", id_pc, 32'hbfc0000c);
    check("hold_rel_id_inst", id_inst, 32'h1a65a5a9);
    check("hold_rel_req", {31'b0, ibus_req}, 32'd1);
    check("hold_rel_addr", ibus_addr, 32'hbfc00010);

    // Flush during an outstanding read.
    $display("scenario: flush during outstanding read");
    wait_cfg = 4; flush = 1'b1; redirect_addr = 32'h80000180; #1;
    check("fl_addr", ibus_addr, 32'hbfc00010);
    tick;
    flush = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      check("drop_addr", ibus_addr, 32'hbfc00010);
      check("drop_id_inst", id_inst, 32'h0);
      check("drop_stallreq", {31'b0, stallreq_o}, 32'd1);
      if (k < 3) tick;
    end
    tick;
    wait_cfg = 0; #1;
    check("redir_addr", ibus_addr, 32'h80000180);
    check("redir_id_inst", id_inst, 32'h0);
    tick;
    check("redir_id_pc", id_pc, 32'h80000180);
    check("redir_id_inst2", id_inst, 32'h25a5a425);

    // Flush coincident with ack.
    $display("scenario: flush with ack");
    flush = 1'b1; redirect_addr = 32'h80000200; #1;
    tick;
    flush = 1'b0; #1;
    check("fa_id_pc", id_pc, 32'h0);
    check("fa_id_inst", id_inst, 32'h0);
    check("fa_addr", ibus_addr, 32'h80000200);
    tick;
    check("fa_next_id_pc", id_pc, 32'h80000200);

    // Flush while holding a buffered word.
    $display("scenario: flush in hold");
    ext_stall = 6'b000111; #1;
    tick;
    flush = 1'b1; redirect_addr = 32'h80000300; ext_stall = 6'b0; #1;
    check("fh_req", {31'b0, ibus_req}, 32'd0);
    tick;
    flush = 1'b0; #1;
    check("fh_id_inst", id_inst, 32'h0);
    check("fh_addr", ibus_addr, 32'h80000300);
    tick;
    check("fh_id_pc", id_pc, 32'h80000300);
    check("fh_id_inst2", id_inst, 32'h25a5a6a5);

    // Reset during DROP.
    $display("scenario: reset during drop");
    wait_cfg = 5; flush = 1'b1; redirect_addr = 32'h80000400; #1;
    tick;
    flush = 1'b0; #1;
    check("rd_addr", ibus_addr, 32'h80000304);
    tick;
    rst = 1'b1; #1;
    check("rd_req_before", {31'b0, ibus_req}, 32'd1);
    tick;
    check("rd_req_after", {31'b0, ibus_req}, 32'd0);
    check("rd_stallreq", {31'b0, stallreq_o}, 32'd1);
    check("rd_id_pc", id_pc, 32'h0);
    check("rd_id_inst", id_inst, 32'h0);
    rst = 1'b0; wait_cfg = 0;

    // Randomized traffic against the model.
    $display("scenario: random traffic");
    for (int n = 0; n < 3000; n++) begin
      tick;
      rst      = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      wait_cfg = $urandom_range(0, 3);
      r = $urandom;
      ext_stall = ($urandom_range(0, 3) == 0) ? {3'b000, r[2:0]} : 6'b0;
      r = $urandom;
      redirect_addr = {r[31:2], 2'b00};
    end
    tick;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
